uart_rx_core: RTL
=================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter: DATA_BITS, 8, number of data bits per frame, legal range 5..8.
REQ-002 Parameter: OVERSAMPLE, 16, baud ticks per bit period, power of two.
REQ-003 Parameter: PARITY_ODD, 0, parity sense (0 even, 1 odd), used only when UART_RX_PARITY_EN is defined.
REQ-004 Port: clock  input  1  system clock, all state on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: baudIn  input  1  baud-generator square wave, one rising edge per oversample tick.
REQ-007 Port: rxIn  input  1  serial line, idle high, asynchronous to clock.
REQ-008 Port: dataOut  output  DATA_BITS  last received word, LSB received first.
REQ-009 Port: dataValid  output  1  one-clock pulse, dataOut holds a new good frame.
REQ-010 Port: frameErr  output  1  one-clock pulse, stop bit sampled low.
REQ-011 Port: parityErr  output  1  one-clock pulse, parity mismatch; tied 0 without UART_RX_PARITY_EN.
REQ-012 Port: busy  output  1  high in every state except IDLE.

Function
REQ-013 rxIn and baudIn each pass a 2-flop synchronizer; tick = one-clock pulse on each synchronized baudIn rising edge.
REQ-014 All state and counters advance only on tick cycles; non-tick cycles hold state.
REQ-015 States: IDLE, START, DATA, PARITY, STOP, BREAK; 4-bit sample counter, bit index counter.
REQ-016 IDLE: tick with synced rx low -> START, counter = 0.
REQ-017 START: counter increments per tick; at counter == OVERSAMPLE/2-1, rx low -> DATA with counter 0, rx high -> IDLE (glitch rejected, no outputs pulse).
REQ-018 DATA: sample rx at counter == OVERSAMPLE-1 into shift register (LSB first), counter wraps to 0; after DATA_BITS samples -> PARITY if enabled else STOP.
REQ-019 PARITY: sample at counter == OVERSAMPLE-1, compare against XOR of data bits per PARITY_ODD; -> STOP.
REQ-020 STOP: sample at counter == OVERSAMPLE-1; rx high -> dataOut updated, dataValid pulse, -> IDLE; rx low -> frameErr pulse, dataOut updated, no dataValid, -> BREAK.
REQ-021 parityErr pulses in the same cycle as dataValid/frameErr; a parity-failed frame still asserts dataValid.
REQ-022 BREAK: wait for tick with synced rx high -> IDLE; no pulses while in BREAK.
REQ-023 Output pulses asserted on the clock after the stop-sample tick, exactly one clock wide.
REQ-024 dataOut changes only at frame end; held otherwise.
REQ-025 Return to IDLE at mid-stop-bit; next start edge detectable on the following tick (back-to-back frames, no lost frame).

Reset
REQ-026 rst high asynchronously forces IDLE, counters 0, synchronizers to idle (rx 1, baud 0).
REQ-027 Reset values: dataOut 0, dataValid 0, frameErr 0, parityErr 0, busy 0.
REQ-028 Reset mid-frame discards the partial frame; no pulse on release.

Configuration
REQ-029 Macro UART_RX_PARITY_EN: defined -> PARITY state and parity check present, frame = start + DATA_BITS + parity + stop.
REQ-030 Undefined -> PARITY state, parity logic removed; parityErr constant 0; DATA goes directly to STOP.

Structure
REQ-031 Package uart_pkg: state enum, OVERSAMPLE default, baud-rate select encodings shared with baud generator.
REQ-032 Sub-module uart_rx_sync: 2-flop synchronizers plus baud rising-edge tick generator; core instantiates one.

Verification
REQ-033 baudIn period 4 clocks, frame 0xA5 8N1 -> dataOut 0xA5, one dataValid pulse, frameErr 0, busy low after.
REQ-034 rxIn low for 4 ticks then high -> no pulses, state IDLE, dataOut unchanged.
REQ-035 Frame 0x3C with stop bit low, line low 20 more bits -> frameErr one pulse, no dataValid, busy high until rx high.
REQ-036 With UART_RX_PARITY_EN, PARITY_ODD 0, 0x01 with parity bit 0 -> dataValid and parityErr same cycle.
REQ-037 rst pulsed mid-DATA of 0xFF, then valid 0x12 -> only 0x12 reported, one dataValid.
REQ-038 Back-to-back 0x55, 0xAA with no idle gap -> two dataValid pulses, values in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversample ratio
// and the baud-rate select encodings also used by the baud generator.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_sel_t;

  function automatic int unsigned baud_rate(input baud_sel_t sel);
    int unsigned rate;
    case (sel)
      BAUD_9600:   rate = 9600;
      BAUD_19200:  rate = 19200;
      BAUD_38400:  rate = 38400;
      BAUD_57600:  rate = 57600;
      BAUD_115200: rate = 115200;
      default:     rate = 9600;
    endcase
    return rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizers for the serial line and baud square wave, plus a
// one-clock tick on every synchronized baud rising edge.
module uart_rx_sync (
  input  logic clock,
  input  logic rst,
  input  logic baudIn,
  input  logic rxIn,
  output logic rx_sync,
  output logic tick
);

  logic [1:0] rx_ff;
  logic [1:0] baud_ff;
  logic       baud_d;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rx_ff   <= '1;
      baud_ff <= '0;
      baud_d  <= 1'b0;
    end else begin
      rx_ff   <= {rx_ff[0], rxIn};
      baud_ff <= {baud_ff[0], baudIn};
      baud_d  <= baud_ff[1];
    end
  end

  assign rx_sync = rx_ff[1];
  assign tick    = baud_ff[1] & ~baud_d;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver core. Optional parity check is built in when
// the UART_RX_PARITY_EN macro is defined; otherwise parityErr is tied low.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 baudIn,
  input  logic                 rxIn,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 dataValid,
  output logic                 frameErr,
  output logic                 parityErr,
  output logic                 busy
);

  localparam int unsigned    CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(OVERSAMPLE - 1);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

  logic                 rx;
  logic                 tick;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 dv_q;
  logic                 fe_q;

  uart_rx_sync u_sync (
    .clock   (clock),
    .rst     (rst),
    .baudIn  (baudIn),
    .rxIn    (rxIn),
    .rx_sync (rx),
    .tick    (tick)
  );

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic par_bad;
  logic pe_q;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  // Pulses are set on the stop-sample tick and cleared on every other clock,
  // so they appear one clock after that tick and are exactly one clock wide.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      dv_q <= 1'b0;
      fe_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q <= 1'b0;
`endif
      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (!rx) begin
              state <= ST_START;
              cnt   <= '0;
            end
          end
          ST_START: begin
            if (cnt == CNT_MID) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= rx ? ST_IDLE : ST_DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DATA: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_END) begin
              shreg   <= {rx, shreg[DATA_BITS-1:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == BIT_LAST) begin
                bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= ST_PARITY;
`else
                state   <= ST_STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_END) begin
              par_bad <= (^shreg) ^ rx ^ ODD;
              state   <= ST_STOP;
            end
          end
`endif
          ST_STOP: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_END) begin
              data_q <= shreg;
`ifdef UART_RX_PARITY_EN
              pe_q   <= par_bad;
`endif
              if (rx) begin
                dv_q  <= 1'b1;
                state <= ST_IDLE;
              end else begin
                fe_q  <= 1'b1;
                state <= ST_BREAK;
              end
            end
          end
          ST_BREAK: begin
            if (rx) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dataOut   = data_q;
  assign dataValid = dv_q;
  assign frameErr  = fe_q;
  assign busy      = (state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parityErr = pe_q;
`else
  assign parityErr = 1'b0;
`endif

endmodule
